// File: rtl/infix_sequencer.sv
// Infix-to-postfix sequencer: shunting-yard over an operator stack, feeding a calculator one token at a time.
// Emission starts the cycle after DECODE and is held until calc_ack; back-to-back emissions are separated by one GAP cycle.
module infix_sequencer #(
    parameter int OP_DEPTH = 16,
    parameter int WIDTH    = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             tok_stb,
    input  logic [WIDTH-1:0] tok_data,
    input  logic             tok_is_op,
    output logic             tok_ack,
    output logic             calc_stb,
    output logic [WIDTH-1:0] calc_data,
    output logic             calc_is_op,
    input  logic             calc_ack,
    input  logic             err_clr,
    output logic             busy,
    output logic             err
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_EXP = 3'b100;
    localparam logic [2:0] OP_EQ  = 3'b101;
    localparam logic [2:0] OP_LP  = 3'b110;
    localparam logic [2:0] OP_RP  = 3'b111;

    localparam int SPW = $clog2(OP_DEPTH + 1);
    localparam int IW  = (OP_DEPTH > 1) ? $clog2(OP_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EMIT, S_WAIT_ACK, S_GAP, S_POP_CHK, S_ERROR
    } state_e;

    typedef enum logic [2:0] {A_POP, A_EQ, A_PUSH, A_DROP, A_ERR} act_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tok_q, tok_d;
    logic             tok_op_q, tok_op_d;
    logic             tok_ack_q, tok_ack_d;
    logic [WIDTH-1:0] calc_data_q, calc_data_d;
    logic             calc_op_q, calc_op_d;
    logic             fin_q, fin_d;
    logic             err_q, err_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic [2:0]       stk_q [OP_DEPTH];

    logic             push_en;
    logic             do_act;
    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    push_idx;
    logic [2:0]       new_op;
    logic [2:0]       top_op;
    logic             empty;
    logic             full;
    act_e             act;

    function automatic logic [1:0] prec(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB: return 2'd1;
            OP_MUL, OP_DIV: return 2'd2;
            default:        return 2'd3;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] op_word(input logic [2:0] op);
        return {{(WIDTH-3){1'b0}}, op};
    endfunction

    assign new_op   = tok_q[2:0];
    assign empty    = (sp_q == '0);
    assign full     = (sp_q == SPW'(OP_DEPTH));
    assign top_idx  = IW'(sp_q - SPW'(1));
    assign push_idx = IW'(sp_q);
    assign top_op   = stk_q[top_idx];

    // One stack step for the operator being processed; evaluated once per visit to POP_CHK or GAP.
    always_comb begin
        act = A_ERR;
        case (new_op)
            OP_RP: begin
                if (empty)                act = A_ERR;
                else if (top_op == OP_LP) act = A_DROP;
                else                      act = A_POP;
            end
            OP_EQ: begin
                if (empty)                act = A_EQ;
                else if (top_op == OP_LP) act = A_ERR;
                else                      act = A_POP;
            end
            default: begin
                if (!empty && top_op != OP_LP &&
                    (prec(top_op) > prec(new_op) ||
                     (prec(top_op) == prec(new_op) && new_op != OP_EXP)))
                    act = A_POP;
                else if (full)
                    act = A_ERR;
                else
                    act = A_PUSH;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            tok_q       <= '0;
            tok_op_q    <= 1'b0;
            tok_ack_q   <= 1'b0;
            calc_data_q <= '0;
            calc_op_q   <= 1'b0;
            fin_q       <= 1'b0;
            err_q       <= 1'b0;
            sp_q        <= '0;
        end else begin
            state_q     <= state_d;
            tok_q       <= tok_d;
            tok_op_q    <= tok_op_d;
            tok_ack_q   <= tok_ack_d;
            calc_data_q <= calc_data_d;
            calc_op_q   <= calc_op_d;
            fin_q       <= fin_d;
            err_q       <= err_d;
            sp_q        <= sp_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_en) stk_q[push_idx] <= new_op;
    end

    always_comb begin
        state_d     = state_q;
        tok_d       = tok_q;
        tok_op_d    = tok_op_q;
        tok_ack_d   = 1'b0;
        calc_data_d = calc_data_q;
        calc_op_d   = calc_op_q;
        fin_d       = fin_q;
        err_d       = err_q;
        sp_d        = sp_q;
        push_en     = 1'b0;
        do_act      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tok_stb) begin
                    tok_d     = tok_data;
                    tok_op_d  = tok_is_op;
                    tok_ack_d = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!tok_op_q) begin
                    state_d = S_EMIT;
                end else if (new_op == OP_LP) begin
                    if (full) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        sp_d    = '0;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SPW'(1);
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_POP_CHK;
                end
            end
            S_EMIT: begin
                calc_data_d = tok_q;
                calc_op_d   = 1'b0;
                fin_d       = 1'b1;
                state_d     = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (calc_ack) state_d = S_GAP;
            end
            S_POP_CHK: do_act = 1'b1;
            S_GAP: begin
                // GAP doubles as the next stack step so consecutive pops keep a single idle cycle.
                if (fin_q) state_d = S_IDLE;
                else       do_act  = 1'b1;
            end
            S_ERROR: begin
                sp_d  = '0;
                err_d = 1'b1;
                if (err_clr) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_act) begin
            case (act)
                A_POP: begin
                    calc_data_d = op_word(top_op);
                    calc_op_d   = 1'b1;
                    fin_d       = 1'b0;
                    sp_d        = sp_q - SPW'(1);
                    state_d     = S_WAIT_ACK;
                end
                A_EQ: begin
                    calc_data_d = op_word(OP_EQ);
                    calc_op_d   = 1'b1;
                    fin_d       = 1'b1;
                    state_d     = S_WAIT_ACK;
                end
                A_PUSH: begin
                    push_en = 1'b1;
                    sp_d    = sp_q + SPW'(1);
                    state_d = S_IDLE;
                end
                A_DROP: begin
                    sp_d    = sp_q - SPW'(1);
                    state_d = S_IDLE;
                end
                default: begin
                    err_d   = 1'b1;
                    sp_d    = '0;
                    state_d = S_ERROR;
                end
            endcase
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        calc_stb   = (state_q == S_WAIT_ACK);
        tok_ack    = tok_ack_q;
        calc_data  = calc_data_q;
        calc_is_op = calc_op_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_infix_sequencer.sv
// Randomized bench for infix_sequencer: token streams are compared against a queue-based shunting-yard model.
module tb_infix_sequencer;
    localparam int W = 32;
    localparam int D = 16;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, DIV = 3'd3;
    localparam logic [2:0] EXP = 3'd4, EQ = 3'd5, LP = 3'd6, RP = 3'd7;

    typedef struct packed {
        logic         is_op;
        logic [W-1:0] val;
    } tok_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         tok_stb = 1'b0;
    logic [W-1:0] tok_data = '0;
    logic         tok_is_op = 1'b0;
    logic         tok_ack;
    logic         calc_stb;
    logic [W-1:0] calc_data;
    logic         calc_is_op;
    logic         calc_ack = 1'b0;
    logic         err_clr = 1'b0;
    logic         busy;
    logic         err;

    int   n_chk = 0;
    int   n_fail = 0;
    tok_t ex_q[$];
    tok_t exp_q[$];
    tok_t obs_q[$];
    int   err_at;
    bit   hold_ack = 1'b0;

    infix_sequencer #(.OP_DEPTH(D), .WIDTH(W)) dut (
        .CLK(CLK), .RST(RST),
        .tok_stb(tok_stb), .tok_data(tok_data), .tok_is_op(tok_is_op), .tok_ack(tok_ack),
        .calc_stb(calc_stb), .calc_data(calc_data), .calc_is_op(calc_is_op), .calc_ack(calc_ack),
        .err_clr(err_clr), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int prec(input logic [2:0] op);
        if (op == ADD || op == SUB) return 1;
        if (op == MUL || op == DIV) return 2;
        return 3;
    endfunction

    function automatic tok_t op_tok(input logic [2:0] c);
        tok_t t;
        t.is_op = 1'b1;
        t.val   = {29'b0, c};
        return t;
    endfunction

    task automatic add_num(input logic [W-1:0] v);
        tok_t t;
        t.is_op = 1'b0;
        t.val   = v;
        ex_q.push_back(t);
    endtask

    // Operator tokens carry junk in the upper bits; the calculator must only see the code.
    task automatic add_op(input logic [2:0] c);
        tok_t t;
        t.is_op = 1'b1;
        t.val   = ($urandom() & 32'hFFFF_FFF8) | {29'b0, c};
        ex_q.push_back(t);
    endtask

    task automatic model();
        logic [2:0] st[$];
        logic [2:0] op;
        logic [2:0] t;
        exp_q.delete();
        err_at = -1;
        for (int i = 0; i < ex_q.size(); i++) begin
            if (!ex_q[i].is_op) begin
                exp_q.push_back(ex_q[i]);
                continue;
            end
            op = ex_q[i].val[2:0];
            if (op == LP) begin
                if (st.size() == D) begin err_at = i; return; end
                st.push_back(op);
            end else if (op == RP) begin
                while (1) begin
                    if (st.size() == 0) begin err_at = i; return; end
                    t = st.pop_back();
                    if (t == LP) break;
                    exp_q.push_back(op_tok(t));
                end
            end else if (op == EQ) begin
                while (st.size() > 0) begin
                    t = st.pop_back();
                    if (t == LP) begin err_at = i; return; end
                    exp_q.push_back(op_tok(t));
                end
                exp_q.push_back(op_tok(EQ));
            end else begin
                while (st.size() > 0 && st[$] != LP &&
                       (prec(st[$]) > prec(op) || (prec(st[$]) == prec(op) && op != EXP)))
                    exp_q.push_back(op_tok(st.pop_back()));
                if (st.size() == D) begin err_at = i; return; end
                st.push_back(op);
            end
        end
    endtask

    task automatic send_tok(input tok_t t, output bit ok);
        int n = 0;
        @(negedge CLK);
        tok_stb   = 1'b1;
        tok_data  = t.val;
        tok_is_op = t.is_op;
        do begin
            @(negedge CLK);
            n++;
        end while (!tok_ack && n < 300);
        tok_stb = 1'b0;
        ok = tok_ack;
        check("tok_ack", 64'(tok_ack), 64'(1));
    endtask

    task automatic run_expr(input string name);
        bit ok;
        bit stb_seen;
        int n;
        model();
        obs_q.delete();
        for (int i = 0; i < ex_q.size(); i++) begin
            if (err_at >= 0 && i > err_at) break;
            send_tok(ex_q[i], ok);
            if (!ok) break;
        end
        if (err_at >= 0) begin
            n = 0;
            while (!err && n < 400) begin @(negedge CLK); n++; end
            check({name, ":err"}, 64'(err), 64'(1));
            stb_seen = 1'b0;
            repeat (6) begin
                @(negedge CLK);
                if (calc_stb) stb_seen = 1'b1;
            end
            check({name, ":quiet"}, 64'(stb_seen), 64'(0));
        end else begin
            n = 0;
            while (busy && n < 400) begin @(negedge CLK); n++; end
            check({name, ":busy"}, 64'(busy), 64'(0));
            check({name, ":noerr"}, 64'(err), 64'(0));
        end
        check({name, ":count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check({name, ":tok"}, 64'(obs_q[i]), 64'(exp_q[i]));
        if (err) begin
            @(negedge CLK); err_clr = 1'b1;
            @(negedge CLK); err_clr = 1'b0;
            check({name, ":clr_err"}, 64'(err), 64'(0));
            check({name, ":clr_busy"}, 64'(busy), 64'(0));
        end
    endtask

    task automatic gen_random();
        int depth = 0;
        int nterms;
        int corrupt;
        ex_q.delete();
        nterms  = $urandom_range(1, 6);
        corrupt = $urandom_range(0, 7);
        for (int t = 0; t < nterms; t++) begin
            while ($urandom_range(0, 3) == 0 && depth < 4) begin add_op(LP); depth++; end
            add_num($urandom());
            while (depth > 0 && $urandom_range(0, 2) == 0) begin add_op(RP); depth--; end
            if (t < nterms - 1) add_op(3'($urandom_range(0, 4)));
        end
        if (corrupt != 1)
            while (depth > 0) begin add_op(RP); depth--; end
        if (corrupt == 0) add_op(RP);
        add_op(EQ);
    endtask

    // Calculator side: random ack delay, checks data stability and the idle cycle after each ack.
    initial begin
        tok_t cap;
        int   d;
        bit   ab;
        forever begin
            @(negedge CLK);
            if (calc_stb && !RST) begin
                cap = {calc_is_op, calc_data};
                d   = $urandom_range(0, 5);
                ab  = 1'b0;
                for (int k = 0; k < d && !ab; k++) begin
                    @(negedge CLK);
                    if (!calc_stb) ab = 1'b1;
                    else check("hold", 64'({calc_is_op, calc_data}), 64'(cap));
                end
                while (!ab && hold_ack) begin
                    @(negedge CLK);
                    if (!calc_stb) ab = 1'b1;
                end
                if (!ab) begin
                    calc_ack = 1'b1;
                    @(negedge CLK);
                    calc_ack = 1'b0;
                    check("gap", 64'(calc_stb), 64'(0));
                    obs_q.push_back(cap);
                end
            end
        end
    end

    task automatic reset_midflight();
        bit   ok;
        int   n;
        tok_t t;
        hold_ack = 1'b1;
        t = op_tok(LP);
        send_tok(t, ok);
        send_tok(t, ok);
        t.is_op = 1'b0;
        t.val   = 32'hDEAD_BEEF;
        send_tok(t, ok);
        n = 0;
        while (!calc_stb && n < 50) begin @(negedge CLK); n++; end
        check("rst:stb_before", 64'(calc_stb), 64'(1));
        #2 RST = 1'b1;
        #1;
        check("rst:calc_stb", 64'(calc_stb), 64'(0));
        check("rst:calc_data", 64'(calc_data), 64'(0));
        check("rst:calc_is_op", 64'(calc_is_op), 64'(0));
        check("rst:busy", 64'(busy), 64'(0));
        check("rst:err", 64'(err), 64'(0));
        check("rst:tok_ack", 64'(tok_ack), 64'(0));
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        hold_ack = 1'b0;
        repeat (3) @(negedge CLK);
        obs_q.delete();
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check("init:tok_ack", 64'(tok_ack), 64'(0));
        check("init:calc_stb", 64'(calc_stb), 64'(0));
        check("init:calc_data", 64'(calc_data), 64'(0));
        check("init:calc_is_op", 64'(calc_is_op), 64'(0));
        check("init:busy", 64'(busy), 64'(0));
        check("init:err", 64'(err), 64'(0));
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        ex_q.delete();
        add_num(3); add_op(ADD); add_num(4); add_op(MUL); add_num(2); add_op(EQ);
        run_expr("prec");

        ex_q.delete();
        add_op(LP); add_num(1); add_op(ADD); add_num(2); add_op(RP); add_op(MUL); add_num(3); add_op(EQ);
        run_expr("paren");

        ex_q.delete();
        add_num(2); add_op(EXP); add_num(3); add_op(EXP); add_num(2); add_op(EQ);
        run_expr("exp_right");

        ex_q.delete();
        add_num(8); add_op(SUB); add_num(3); add_op(SUB); add_num(1); add_op(EQ);
        run_expr("sub_left");

        ex_q.delete();
        add_num(9); add_op(DIV); add_num(3); add_op(MUL); add_num(2); add_op(EQ);
        run_expr("div_mul");

        ex_q.delete();
        add_num(5); add_op(RP);
        run_expr("rp_empty");

        ex_q.delete();
        for (int i = 0; i < 17; i++) add_op(LP);
        run_expr("lp_overflow");

        ex_q.delete();
        for (int i = 0; i < 16; i++) add_op(LP);
        add_op(ADD);
        run_expr("op_overflow");

        ex_q.delete();
        add_op(LP); add_num(4); add_op(EQ);
        run_expr("eq_open_lp");

        for (int r = 0; r < 40; r++) begin
            gen_random();
            run_expr("rand");
        end

        reset_midflight();

        ex_q.delete();
        add_num(3); add_op(ADD); add_num(4); add_op(MUL); add_num(2); add_op(EQ);
        run_expr("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/infix_sequencer.md
INFIX_SEQUENCER -- requirements
Module: infix_sequencer

Interface
REQ-001 SHALL have parameter OP_DEPTH, default 16: operator-stack entries.
REQ-002 SHALL have parameter WIDTH, default 32: token/data width.
REQ-003 SHALL have CLK  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have tok_stb  input  1  upstream infix token valid.
REQ-006 SHALL have tok_data  input  WIDTH  number, or operator code in [2:0].
REQ-007 SHALL have tok_is_op  input  1  1 = operator token.
REQ-008 SHALL have tok_ack  output  1  one-cycle pulse, token consumed.
REQ-009 SHALL have calc_stb  output  1  postfix token valid to calculator.
REQ-010 SHALL have calc_data  output  WIDTH  postfix token.
REQ-011 SHALL have calc_is_op  output  1  1 = operator token.
REQ-012 SHALL have calc_ack  input  1  calculator token-accept pulse.
REQ-013 SHALL have err_clr  input  1  clears the error state.
REQ-014 SHALL have busy  output  1  high when not in IDLE.
REQ-015 SHALL have err  output  1  sticky syntax/overflow error.

Function
REQ-016 Operator codes SHALL be: ADD 000, SUB 001, MUL 010, DIV 011, EXP 100, EQ 101, LP 110, RP 111.
REQ-017 Precedence SHALL be: ADD/SUB 1, MUL/DIV 2, EXP 3; EXP right-associative, all others left-associative.
REQ-018 FSM states SHALL be IDLE, DECODE, EMIT, WAIT_ACK, GAP, POP_CHK, ERROR.
REQ-019 In IDLE with tok_stb=1, the block SHALL latch tok_data/tok_is_op, pulse tok_ack for one cycle, and go to DECODE; tok_stb SHALL be ignored in all other states.
REQ-020 A number token SHALL be emitted unchanged with calc_is_op=0, then the FSM SHALL return to IDLE.
REQ-021 LP SHALL be pushed without emission; a push onto a full stack (OP_DEPTH entries) SHALL go to ERROR.
REQ-022 For ADD..EXP, the block SHALL pop and emit while top is not LP and (prec(top)>prec(new), or equal and new is left-assoc), then push the new operator.
REQ-023 RP SHALL pop and emit until LP; LP SHALL be discarded and nothing emitted for RP; an empty stack before LP SHALL go to ERROR.
REQ-024 EQ SHALL pop and emit all entries, then emit EQ (calc_data[2:0]=101, calc_is_op=1), then return to IDLE; an LP found during the drain SHALL go to ERROR.
REQ-025 An emitted operator SHALL carry its code in calc_data[2:0], zeros in upper bits, and calc_is_op=1.
REQ-026 Emit handshake: calc_stb/calc_data/calc_is_op SHALL be held stable from assertion until the cycle calc_ack=1 is sampled (WAIT_ACK).
REQ-027 In the cycle after the ack, calc_stb SHALL be deasserted for exactly one cycle (GAP) before any next emission.
REQ-028 Emission SHALL start no earlier than the cycle after DECODE; one stack pop or push SHALL happen per cycle at most.
REQ-029 calc_ack outside WAIT_ACK SHALL be ignored.
REQ-030 ERROR SHALL set err=1, empty the operator stack, and hold calc_stb=0 and tok_ack=0.
REQ-031 ERROR SHALL exit to IDLE only on err_clr=1, which clears err in the same edge; err_clr SHALL have no effect in other states.
REQ-032 The stack pointer SHALL never wrap: no pop on empty, no push on full.

Reset
REQ-033 On RST=1, asynchronously: state=IDLE, stack empty, tok_ack=0, calc_stb=0, calc_data=0, calc_is_op=0, busy=0, err=0.
REQ-034 RST mid-emission SHALL drop calc_stb immediately; the in-flight token SHALL be lost with no replay.

Verification
REQ-035 Input 3,+,4,*,2,= -> calculator SHALL see 3,4,2,MUL,ADD,EQ; err=0, busy=0 at end.
REQ-036 Input (,1,+,2,),*,3,= -> calculator SHALL see 1,2,ADD,3,MUL,EQ.
REQ-037 Input 2,^,3,^,2,= -> calculator SHALL see 2,3,2,EXP,EXP,EQ; input 8,-,3,-,1,= -> 8,3,SUB,1,SUB,EQ.
REQ-038 Input 5,) -> 5 emitted, then err=1 and no further calc_stb; err_clr pulse -> IDLE, err=0.
REQ-039 Input 17 consecutive LP with OP_DEPTH=16 -> err=1 on the 17th; input (,4,= -> 4 emitted, then err=1 with no EQ emitted.
REQ-040 Bench SHALL delay calc_ack 0..5 cycles and assert RST while calc_stb=1 -> outputs zero at once, next expression correct.
